poly_load_unit: RTL and testbench

Upstream loader for `operation_module`'s BRAM 1. It accepts a valid/ready stream of 256 polynomial coefficients and normalises each into [0, Q). It packs four coefficients per 96-bit word and writes the 64 words to the BRAM write port. A one-cycle `done` pulse then tells the top-level controller that the polynomial is ready for NTT, mult, add or sub.

---
 rtl/dilithium_pkg.sv | 28 ++
 rtl/coeff_normalize.sv | 56 +++++
 rtl/poly_load_unit.sv | 173 +++++++++++++++++
 tb/tb_poly_load_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dilithium_pkg.sv
// -----------------------------------------------------------------------------
// dilithium_pkg
// Shared constants and types for the polynomial datapath blocks.
//   Q        : coefficient modulus (23-bit value)
//   COEFF_W  : width of one coefficient lane
//   WORD_W   : width of one packed BRAM word (4 lanes)
//   N_COEFFS : coefficients per polynomial
//   N_WORDS  : packed words per polynomial
//   load_state_t : state encoding of the polynomial loader
// -----------------------------------------------------------------------------
package dilithium_pkg;

    localparam int unsigned Q        = 8380417;
    localparam int          COEFF_W  = 24;
    localparam int          LANES    = 4;
    localparam int          WORD_W   = COEFF_W * LANES;
    localparam int          N_COEFFS = 256;
    localparam int          N_WORDS  = N_COEFFS / LANES;

    // IDLE must stay at zero so a reset register value reads as IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } load_state_t;

endpackage

// File: rtl/coeff_normalize.sv
// -----------------------------------------------------------------------------
// coeff_normalize
// Registered single-step reduction of one coefficient into [0, Q).
//   clk         : clock, rising edge
//   rst         : asynchronous reset, active low
//   en          : capture din this cycle
//   signed_mode : 1 = din is two's complement in (-Q, Q), 0 = din in [0, 2Q)
//   din         : raw coefficient
//   dout        : normalised coefficient, bit 23 always 0
//   dout_valid  : dout was captured on the previous edge
// Inputs outside the stated ranges produce an unspecified lane value.
// -----------------------------------------------------------------------------
module coeff_normalize
    import dilithium_pkg::*;
#(
    parameter int unsigned MODULUS = dilithium_pkg::Q
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               signed_mode,
    input  logic [COEFF_W-1:0] din,
    output logic [COEFF_W-1:0] dout,
    output logic               dout_valid
);

    localparam logic [COEFF_W-1:0] MOD_W = COEFF_W'(MODULUS);

    logic [COEFF_W-1:0] r_next;

    // One conditional add (negative signed input) or subtract (unsigned >= Q);
    // the add relies on 24-bit wrap to land in [1, Q).
    always_comb begin
        r_next = din;
        if (signed_mode) begin
            if (din[COEFF_W-1]) begin
                r_next = din + MOD_W;
            end
        end else if (din >= MOD_W) begin
            r_next = din - MOD_W;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= en;
            if (en) begin
                dout <= {1'b0, r_next[COEFF_W-2:0]};
            end
        end
    end

endmodule

// File: rtl/poly_load_unit.sv
// -----------------------------------------------------------------------------
// poly_load_unit
// Loads one 256-coefficient polynomial from a valid/ready stream into a BRAM
// write port, normalising each coefficient and packing four per 96-bit word.
//   clk       : clock, rising edge
//   rst       : asynchronous reset, active low
//   start     : request one load (honoured in IDLE only)
//   signed_in : coefficient format, latched with start
//   din       : coefficient, din_valid / din_ready handshake
//   we/addr/dout : registered BRAM write port (web1/addrb1/dib1)
//   done      : one-cycle pulse after the last word write
//   busy      : high outside IDLE
// Pipeline: accept edge -> normalise register -> pack/write register.
// -----------------------------------------------------------------------------
module poly_load_unit
    import dilithium_pkg::*;
#(
    parameter int unsigned Q       = dilithium_pkg::Q,
    parameter int unsigned N_WORDS = dilithium_pkg::N_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_in,
    input  logic [23:0]       din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              we,
    output logic [5:0]        addr,
    output logic [WORD_W-1:0] dout,
    output logic              done,
    output logic              busy
);

    localparam logic [5:0] LAST_WORD = 6'(N_WORDS - 1);
    localparam logic [1:0] LAST_LANE = 2'(LANES - 1);

    load_state_t        state_reg, state_next;
    logic [1:0]         lane_cnt_reg;
    logic [5:0]         word_cnt_reg;
    logic               signed_mode_reg;

    // Position tags travelling alongside the normalise stage.
    logic [1:0]         s1_lane_reg;
    logic [5:0]         s1_word_reg;
    logic [COEFF_W-1:0] s1_data;
    logic               s1_valid;

    // Lanes 0..2 wait here until lane 3 arrives and completes the word.
    logic [COEFF_W-1:0] lane_buf_reg [0:LANES-2];

    logic               we_reg;
    logic [5:0]         addr_reg;
    logic [WORD_W-1:0]  dout_reg;

    logic               accept;
    logic               last_accept;
    logic               last_write_issued;
    logic               s1_word_complete;

    assign accept            = din_valid & din_ready;
    assign last_accept       = accept && (lane_cnt_reg == LAST_LANE)
                                      && (word_cnt_reg == LAST_WORD);
    assign last_write_issued = we_reg && (addr_reg == LAST_WORD);
    assign s1_word_complete  = s1_valid && (s1_lane_reg == LAST_LANE);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start)             state_next = ST_LOAD;
            ST_LOAD:  if (last_accept)       state_next = ST_DRAIN;
            ST_DRAIN: if (last_write_issued) state_next = ST_FIN;
            ST_FIN:                          state_next = ST_IDLE;
            default:                         state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        din_ready = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
        case (state_reg)
            ST_IDLE: busy      = 1'b0;
            ST_LOAD: din_ready = 1'b1;
            ST_FIN:  done      = 1'b1;
            default: ;
        endcase
    end

    // ---------------- accept counters and mode latch ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_cnt_reg    <= '0;
            word_cnt_reg    <= '0;
            signed_mode_reg <= 1'b0;
            s1_lane_reg     <= '0;
            s1_word_reg     <= '0;
        end else begin
            if (state_reg == ST_IDLE && start) begin
                lane_cnt_reg    <= '0;
                word_cnt_reg    <= '0;
                signed_mode_reg <= signed_in;
            end else if (accept) begin
                lane_cnt_reg <= lane_cnt_reg + 2'd1;
                if (lane_cnt_reg == LAST_LANE) begin
                    word_cnt_reg <= word_cnt_reg + 6'd1;
                end
            end
            if (accept) begin
                s1_lane_reg <= lane_cnt_reg;
                s1_word_reg <= word_cnt_reg;
            end
        end
    end

    // ---------------- stage 1: normalise ----------------
    coeff_normalize #(
        .MODULUS (Q)
    ) u_norm (
        .clk         (clk),
        .rst         (rst),
        .en          (accept),
        .signed_mode (signed_mode_reg),
        .din         (din),
        .dout        (s1_data),
        .dout_valid  (s1_valid)
    );

    // ---------------- stage 2: lane buffer ----------------
    generate
        for (genvar gi = 0; gi < LANES - 1; gi++) begin : g_lane
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    lane_buf_reg[gi] <= '0;
                end else if (s1_valid && s1_lane_reg == 2'(gi)) begin
                    lane_buf_reg[gi] <= s1_data;
                end
            end
        end
    endgenerate

    // ---------------- stage 2: word write ----------------
    // Lane 3 bypasses the buffer and goes straight into the packed word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_reg   <= 1'b0;
            addr_reg <= '0;
            dout_reg <= '0;
        end else begin
            we_reg <= s1_word_complete;
            if (s1_word_complete) begin
                addr_reg <= s1_word_reg;
                dout_reg <= {s1_data, lane_buf_reg[2], lane_buf_reg[1], lane_buf_reg[0]};
            end
        end
    end

    assign we   = we_reg;
    assign addr = addr_reg;
    assign dout = dout_reg;

endmodule

// File: tb/tb_poly_load_unit.sv
// -----------------------------------------------------------------------------
// tb_poly_load_unit
// Table-driven normalisation vectors, ramp and random streams against a
// modular-arithmetic reference, plus reset-abort and ignored-start sequences.
// -----------------------------------------------------------------------------
module tb_poly_load_unit;

    localparam int QM = 8380417;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        signed_in = 1'b0;
    logic [23:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic        we;
    logic [5:0]  addr;
    logic [95:0] dout;
    logic        done;
    logic        busy;

    poly_load_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_in (signed_in),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .we        (we),
        .addr      (addr),
        .dout      (dout),
        .done      (done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- BRAM model / monitor ----------------
    logic [95:0] bram [64];
    int we_count, done_count, next_addr, order_err;
    int first_we_cyc, last_we_cyc, done_cyc;

    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (we_count == 0) first_we_cyc = cyc;
            bram[addr] = dout;
            if (int'(addr) != next_addr) order_err++;
            next_addr++;
            we_count++;
            last_we_cyc = cyc;
        end
        if (done === 1'b1) begin
            done_count++;
            done_cyc = cyc;
        end
    end

    // ---------------- reference model ----------------
    int coef [256];
    int accept_cyc [256];
    bit mode;

    function automatic int ref_norm(bit sgn, int raw);
        int v;
        v = raw;
        if (sgn && raw >= (1 << 23)) v = raw - (1 << 24);
        return ((v % QM) + QM) % QM;
    endfunction

    function automatic logic [95:0] ref_word(int a);
        logic [95:0] w;
        for (int k = 0; k < 4; k++) w[24*k +: 24] = 24'(ref_norm(mode, coef[4*a+k]));
        return w;
    endfunction

    // ---------------- checking ----------------
    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clear_monitor();
        we_count = 0; done_count = 0; next_addr = 0; order_err = 0;
        first_we_cyc = -1; last_we_cyc = -1; done_cyc = -1;
        for (int i = 0; i < 64; i++) bram[i] = 'x;
    endtask

    // Drives n_accepts coefficients; start is pulsed again at coefficient start_again_at.
    task automatic run_load(input bit sgn, input int gap_pct, input int n_accepts,
                            input int start_again_at);
        int  i, budget;
        logic rdy;
        clear_monitor();
        mode = sgn;
        @(posedge clk); #1;
        start = 1'b1; signed_in = sgn;
        @(posedge clk); #1;
        start = 1'b0; signed_in = ~sgn;   // must not matter after start
        i = 0; budget = 0;
        while (i < n_accepts && budget < 4000) begin
            din       = 24'(coef[i]);
            din_valid = ($urandom_range(0, 99) >= gap_pct);
            start     = (i == start_again_at);
            rdy       = din_ready;
            @(posedge clk); #1;
            budget++;
            if (din_valid && rdy) begin
                accept_cyc[i] = cyc;
                $display("accept %0d din=%06h cyc=%0d", i, din, cyc);
                i++;
            end
        end
        din_valid = 1'b0;
        start     = 1'b0;
        if (i < n_accepts) check("accept budget", 96'(i), 96'(n_accepts));
    endtask

    task automatic verify_load(input string tag);
        int k;
        k = 0;
        while (done_count == 0 && k < 20) begin
            @(negedge clk); #1;
            k++;
        end
        check({tag, " done seen"}, 96'(done_count), 96'd1);
        check({tag, " we pulses"}, 96'(we_count), 96'd64);
        check({tag, " addr order"}, 96'(order_err), 96'd0);
        check({tag, " first write latency"}, 96'(first_we_cyc), 96'(accept_cyc[3] + 1));
        check({tag, " last write latency"}, 96'(last_we_cyc), 96'(accept_cyc[255] + 1));
        check({tag, " done after last we"}, 96'(done_cyc), 96'(last_we_cyc + 1));
        for (int a = 0; a < 64; a++) begin
            $display("%s word %0d = %024h", tag, a, bram[a]);
            check({tag, $sformatf(" word %0d", a)}, bram[a], ref_word(a));
        end
        @(negedge clk); #1;
        check({tag, " busy low after done"}, 96'(busy), 96'd0);
        repeat (4) @(negedge clk);
        #1;
        check({tag, " single done"}, 96'(done_count), 96'd1);
    endtask

    typedef struct {
        bit          sgn;
        logic [23:0] din;
        logic [23:0] lane;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int we_before;

        vecs[0] = '{1'b1, 24'hFFFFFF, 24'd8380416};   // -1
        vecs[1] = '{1'b1, 24'h802000, 24'd1};         // -(Q-1)
        vecs[2] = '{1'b0, 24'd8380417, 24'd0};        // Q
        vecs[3] = '{1'b0, 24'd16760833, 24'd8380416}; // 2Q-1
        vecs[4] = '{1'b1, 24'h7FE000, 24'd8380416};   // Q-1 signed positive
        vecs[5] = '{1'b0, 24'd8380416, 24'd8380416};  // Q-1 unsigned

        // ---- reset state ----
        clear_monitor();
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", {din_ready, we, addr, dout, done, busy}, '0);
        rst = 1'b1;

        // ---- din_valid in IDLE is ignored ----
        din_valid = 1'b1; din = 24'd5;
        repeat (5) @(posedge clk);
        #1;
        check("idle ready", 96'(din_ready), 96'd0);
        check("idle writes", 96'(we_count), 96'd0);
        din_valid = 1'b0;

        // ---- unsigned ramp, continuous valid ----
        for (int i = 0; i < 256; i++) coef[i] = i;
        run_load(1'b0, 0, 256, -1);
        verify_load("ramp");
        check("ramp word0", bram[0], {24'd3, 24'd2, 24'd1, 24'd0});
        check("ramp word63 lane3", 96'(bram[63][95:72]), 96'd255);
        check("ramp write spacing", 96'(last_we_cyc - first_we_cyc), 96'd252);

        // ---- table-driven normalisation vectors ----
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 256; i++) coef[i] = int'(vecs[v].din);
            run_load(vecs[v].sgn, 0, 256, -1);
            verify_load($sformatf("vec%0d", v));
            check($sformatf("vec%0d table word0", v), bram[0], {4{vecs[v].lane}});
            check($sformatf("vec%0d table word63", v), bram[63], {4{vecs[v].lane}});
        end

        // ---- random streams with 30% idle cycles, both modes ----
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 256; i++) begin
                if (r == 0) begin
                    coef[i] = $urandom_range(0, 2*QM - 1);
                end else begin
                    int sv;
                    sv = $urandom_range(0, 2*QM - 2) - (QM - 1);
                    coef[i] = (sv < 0) ? sv + (1 << 24) : sv;
                end
            end
            run_load(bit'(r), 30, 256, -1);
            verify_load($sformatf("rand%0d", r));
        end

        // ---- second start mid-load is ignored ----
        for (int i = 0; i < 256; i++) coef[i] = $urandom_range(0, 2*QM - 1);
        run_load(1'b0, 10, 256, 100);
        verify_load("restart");

        // ---- reset after 130 accepts aborts ----
        for (int i = 0; i < 256; i++) coef[i] = $urandom_range(0, 2*QM - 1);
        run_load(1'b0, 30, 130, -1);
        rst = 1'b0;
        @(negedge clk); #1;
        check("abort outputs", {din_ready, we, addr, dout, done, busy}, '0);
        we_before = we_count;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("abort no done", 96'(done_count), 96'd0);
        check("abort no writes", 96'(we_count), 96'(we_before));
        check("abort idle", 96'(busy), 96'd0);

        for (int i = 0; i < 256; i++) coef[i] = $urandom_range(0, 2*QM - 1);
        run_load(1'b0, 0, 256, -1);
        verify_load("after_abort");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global time limit.
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
